// File: rtl/multiport_reg_file_pkg.sv
// Shared types and helpers for the multiport register file slice.
// The write-first bypass option is selected by the macro RF_BYPASS_EN.
package rf_pkg;

  localparam int RF_MAX_DEPTH = 256;

  typedef enum logic {RF_OK, RF_OOR} rf_addr_err_e;

  // Address width for a given depth, never less than one bit.
  function automatic int rf_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/multiport_reg_file_if.sv
// Bus bundle for the 1-write / 2-read register file.
// The master drives requests; the slave (register file) returns read data and status.
interface multiport_reg_file_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 3
);
  logic                  WrEn;
  logic [ADDR_W-1:0]     WrAddr;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  RdEnA;
  logic [ADDR_W-1:0]     RdAddrA;
  logic [DATA_WIDTH-1:0] RdDataA;
  logic                  RdValidA;
  logic                  RdEnB;
  logic [ADDR_W-1:0]     RdAddrB;
  logic [DATA_WIDTH-1:0] RdDataB;
  logic                  RdValidB;
  logic                  AddrErr;

  modport master (
    output WrEn, WrAddr, WrData, RdEnA, RdAddrA, RdEnB, RdAddrB,
    input  RdDataA, RdValidA, RdDataB, RdValidB, AddrErr
  );

  modport slave (
    input  WrEn, WrAddr, WrData, RdEnA, RdAddrA, RdEnB, RdAddrB,
    output RdDataA, RdValidA, RdDataB, RdValidB, AddrErr
  );
endinterface

// File: rtl/multiport_reg_file_read_port.sv
// One registered read port: range check, zero-register masking and, when RF_BYPASS_EN
// is defined, write-first forwarding from the concurrent write.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 3,
  parameter int DEPTH      = 8,
  parameter int ZERO_REG   = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_word,
`ifdef RF_BYPASS_EN
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`endif
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_oor
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  rf_addr_err_e          addr_st;
  logic                  is_zero;
  logic [DATA_WIDTH-1:0] next_data;

  always_comb begin
    addr_st   = ({1'b0, rd_addr} < DEPTH_X) ? RF_OK : RF_OOR;
    is_zero   = (ZERO_REG != 0) && (rd_addr == '0);
    next_data = mem_word;
    if (addr_st == RF_OOR || is_zero)
      next_data = '0;
`ifdef RF_BYPASS_EN
    // Matching valid address implies the write lands, so forward its data.
    else if (wr_en && wr_addr == rd_addr)
      next_data = wr_data;
`endif
  end

  assign rd_oor = rd_en && (addr_st == RF_OOR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= next_data;
    end
  end

endmodule

// File: rtl/multiport_reg_file.sv
// Parametrised 1-write / 2-read register file with sticky address-range error flag.
// Define RF_BYPASS_EN for write-first forwarding on same-address collisions.
module multiport_reg_file
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ZERO_REG   = 0
) (
  input logic                 CLK,
  input logic                 RST,
  multiport_reg_file_if.slave bus
);

  localparam int              ADDR_W  = rf_clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] word_a, word_b;
  logic                  wr_in_range, wr_take, oor_a, oor_b, addr_err;

  assign wr_in_range = {1'b0, bus.WrAddr} < DEPTH_X;
  assign wr_take     = bus.WrEn && wr_in_range && !((ZERO_REG != 0) && (bus.WrAddr == '0));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_take) begin
      mem[bus.WrAddr] <= bus.WrData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      addr_err <= 1'b0;
    else if ((bus.WrEn && !wr_in_range) || oor_a || oor_b)
      addr_err <= 1'b1;
  end

  assign bus.AddrErr = addr_err;

  // Out-of-range words are masked to zero inside the ports.
  assign word_a = mem[bus.RdAddrA];
  assign word_b = mem[bus.RdAddrB];

  rf_read_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .CLK      (CLK),
    .RST      (RST),
    .rd_en    (bus.RdEnA),
    .rd_addr  (bus.RdAddrA),
    .mem_word (word_a),
`ifdef RF_BYPASS_EN
    .wr_en    (bus.WrEn),
    .wr_addr  (bus.WrAddr),
    .wr_data  (bus.WrData),
`endif
    .rd_data  (bus.RdDataA),
    .rd_valid (bus.RdValidA),
    .rd_oor   (oor_a)
  );

  rf_read_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .CLK      (CLK),
    .RST      (RST),
    .rd_en    (bus.RdEnB),
    .rd_addr  (bus.RdAddrB),
    .mem_word (word_b),
`ifdef RF_BYPASS_EN
    .wr_en    (bus.WrEn),
    .wr_addr  (bus.WrAddr),
    .wr_data  (bus.WrData),
`endif
    .rd_data  (bus.RdDataB),
    .rd_valid (bus.RdValidB),
    .rd_oor   (oor_b)
  );

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed bench for multiport_reg_file: dut0 is DEPTH=8/ZERO_REG=0, dut1 is DEPTH=6/ZERO_REG=1.
// Expected read results are queued per port when a read is issued and popped on the strobe.
module tb_multiport_reg_file;
  import rf_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  multiport_reg_file_if #(.DATA_WIDTH(16), .ADDR_W(3)) if0 ();
  multiport_reg_file_if #(.DATA_WIDTH(16), .ADDR_W(3)) if1 ();

  multiport_reg_file #(.DATA_WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut0 (
    .CLK(CLK), .RST(RST), .bus(if0.slave));
  multiport_reg_file #(.DATA_WIDTH(16), .DEPTH(6), .ZERO_REG(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(if1.slave));

  typedef struct {
    logic [15:0]  data;
    rf_addr_err_e kind;
  } exp_t;

  exp_t        qa0[$], qb0[$], qa1[$], qb1[$];
  logic [15:0] mdl [2][8];
  logic [15:0] last_exp [4];
  logic        err_exp [2];
  logic        err_pend [2];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int p, input exp_t e);
    case (p)
      0: qa0.push_back(e);
      1: qb0.push_back(e);
      2: qa1.push_back(e);
      default: qb1.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int p);
    case (p)
      0: return qa0.size();
      1: return qb0.size();
      2: return qa1.size();
      default: return qb1.size();
    endcase
  endfunction

  function automatic exp_t pop(input int p);
    case (p)
      0: return qa0.pop_front();
      1: return qb0.pop_front();
      2: return qa1.pop_front();
      default: return qb1.pop_front();
    endcase
  endfunction

  function automatic exp_t model_rd(input int d, input logic [2:0] a, input logic we,
                                    input logic [2:0] wa, input logic [15:0] wd);
    exp_t e;
    int   depth;
    depth  = (d == 1) ? 6 : 8;
    e.kind = (int'(a) >= depth) ? RF_OOR : RF_OK;
    if (e.kind == RF_OOR || (d == 1 && a == 3'd0))
      e.data = 16'h0000;
`ifdef RF_BYPASS_EN
    else if (we && wa == a)
      e.data = wd;
`endif
    else
      e.data = mdl[d][a];
    return e;
  endfunction

  task automatic idle();
    if0.WrEn = 0; if0.WrAddr = 0; if0.WrData = 0;
    if0.RdEnA = 0; if0.RdAddrA = 0; if0.RdEnB = 0; if0.RdAddrB = 0;
    if1.WrEn = 0; if1.WrAddr = 0; if1.WrData = 0;
    if1.RdEnA = 0; if1.RdAddrA = 0; if1.RdEnB = 0; if1.RdAddrB = 0;
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) mdl[d][i] = 16'h0000;
      err_exp[d]  = 1'b0;
      err_pend[d] = 1'b0;
    end
    for (int p = 0; p < 4; p++) last_exp[p] = 16'h0000;
    qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
  endtask

  // Drive one cycle of requests on DUT d and record what it must return.
  task automatic set(input int d, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic rea, input logic [2:0] raa, input logic reb, input logic [2:0] rab);
    int depth;
    depth = (d == 1) ? 6 : 8;
    if (d == 0) begin
      if0.WrEn = we; if0.WrAddr = wa; if0.WrData = wd;
      if0.RdEnA = rea; if0.RdAddrA = raa; if0.RdEnB = reb; if0.RdAddrB = rab;
    end else begin
      if1.WrEn = we; if1.WrAddr = wa; if1.WrData = wd;
      if1.RdEnA = rea; if1.RdAddrA = raa; if1.RdEnB = reb; if1.RdAddrB = rab;
    end
    if (rea) push(2*d,   model_rd(d, raa, we, wa, wd));
    if (reb) push(2*d+1, model_rd(d, rab, we, wa, wd));
    if ((we && int'(wa) >= depth) || (rea && int'(raa) >= depth) || (reb && int'(rab) >= depth))
      err_pend[d] = 1'b1;
    if (we && int'(wa) < depth && !(d == 1 && wa == 3'd0))
      mdl[d][wa] = wd;
  endtask

  task automatic chk_port(input int p, input string tag, input logic en_pre,
                          input logic valid, input logic [15:0] data);
    exp_t e;
    check({tag, ".valid"}, {15'd0, valid}, {15'd0, en_pre});
    if (en_pre) begin
      if (qsize(p) == 0) begin
        total++;
        bad++;
        $error("FAIL %s.sb: observed=strobe expected=queued entry", tag);
      end else begin
        e = pop(p);
        check({tag, (e.kind == RF_OOR) ? ".oor_data" : ".data"}, data, e.data);
        last_exp[p] = e.data;
      end
    end else begin
      check({tag, ".hold"}, data, last_exp[p]);
    end
  endtask

  task automatic tick();
    logic [3:0] en;
    en = {if1.RdEnB, if1.RdEnA, if0.RdEnB, if0.RdEnA};
    @(posedge CLK);
    #1;
    chk_port(0, "A0", en[0], if0.RdValidA, if0.RdDataA);
    chk_port(1, "B0", en[1], if0.RdValidB, if0.RdDataB);
    chk_port(2, "A1", en[2], if1.RdValidA, if1.RdDataA);
    chk_port(3, "B1", en[3], if1.RdValidB, if1.RdDataB);
    for (int d = 0; d < 2; d++) begin
      err_exp[d]  = err_exp[d] | err_pend[d];
      err_pend[d] = 1'b0;
    end
    check("err0", {15'd0, if0.AddrErr}, {15'd0, err_exp[0]});
    check("err1", {15'd0, if1.AddrErr}, {15'd0, err_exp[1]});
    idle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, ".A0d"}, if0.RdDataA, 16'h0000);
    check({tag, ".B0d"}, if0.RdDataB, 16'h0000);
    check({tag, ".A1d"}, if1.RdDataA, 16'h0000);
    check({tag, ".B1d"}, if1.RdDataB, 16'h0000);
    check({tag, ".vld"}, {12'd0, if0.RdValidA, if0.RdValidB, if1.RdValidA, if1.RdValidB}, 16'h0000);
    check({tag, ".err"}, {14'd0, if0.AddrErr, if1.AddrErr}, 16'h0000);
  endtask

  initial begin
    idle();
    reset_model();
    RST = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge CLK);
    RST = 1'b1;

    // Latency and dual read
    set(0, 1, 3'd1, 16'hAAAA, 0, 0, 0, 0); tick();
    set(0, 1, 3'd6, 16'h5555, 0, 0, 0, 0); tick();
    set(0, 0, 0, 0, 1, 3'd1, 1, 3'd6);     tick();
    tick();

    // Same-address collision, then both ports plus write on one address
    set(0, 1, 3'd2, 16'h0F0F, 0, 0, 0, 0); tick();
    set(0, 1, 3'd2, 16'hBEEF, 1, 3'd2, 0, 0); tick();
    set(0, 0, 0, 0, 1, 3'd2, 1, 3'd2);     tick();
    set(0, 1, 3'd2, 16'h1357, 1, 3'd2, 1, 3'd2); tick();
    set(0, 0, 0, 0, 0, 0, 1, 3'd2);        tick();

    // Register 0 is ordinary on dut0
    set(0, 1, 3'd0, 16'h00C3, 0, 0, 0, 0); tick();
    set(0, 0, 0, 0, 1, 3'd0, 1, 3'd7);     tick();

    // Hold behaviour while the read address is rewritten
    set(0, 0, 0, 0, 1, 3'd1, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set(0, 1, 3'd1, 16'($urandom), 0, 0, 0, 0);
      tick();
    end
    set(0, 0, 0, 0, 1, 3'd1, 0, 0); tick();

    // ZERO_REG on dut1
    set(1, 1, 3'd0, 16'hFFFF, 1, 3'd0, 1, 3'd0); tick();
    set(1, 0, 0, 0, 1, 3'd0, 1, 3'd0);          tick();

    // Out of range on dut1 (DEPTH=6)
    for (int i = 1; i < 6; i++) begin
      set(1, 1, 3'(i), 16'h1100 + 16'(i), 0, 0, 0, 0);
      tick();
    end
    set(1, 1, 3'd7, 16'h7777, 0, 0, 0, 0); tick();
    set(1, 0, 0, 0, 1, 3'd7, 1, 3'd5);     tick();
    for (int i = 0; i < 6; i++) begin
      set(1, 0, 0, 0, 1, 3'(i), 1, 3'd6);
      tick();
    end
    tick();

    // Asynchronous reset with a write and a read in flight
    set(0, 1, 3'd3, 16'h1234, 0, 0, 0, 0); tick();
    set(0, 0, 0, 0, 1, 3'd3, 0, 0);        tick();
    set(0, 1, 3'd5, 16'hABCD, 1, 3'd5, 0, 0);
    #2;
    RST = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    reset_model();
    idle();
    @(posedge CLK);
    #1;
    chk_reset_outputs("rst_hold");
    @(negedge CLK);
    RST = 1'b1;
    set(0, 0, 0, 0, 1, 3'd3, 1, 3'd5);     tick();
    set(1, 0, 0, 0, 1, 3'd3, 0, 0);        tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
